irq_vector_controller: RTL and testbench
========================================

Name: irq_vector_controller

Overview:
Parametrised Wishbone-slave interrupt aggregator for the monitor processor bus. It collects up to 15 hardware sources plus one software (user) interrupt. Each source has a selectable edge/level mode and polarity, a sticky flag, and a mask. The block drives a single registered interrupt line and exposes a priority-encoded vector register, so the handler can find the pending source without scanning the flags.

Parameters:
NUM_SOURCES, 8, number of hardware sources; legal range 1..15. The user bit occupies flag index NUM_SOURCES.
MODE_RST, all ones, reset value of MODE (NUM_SOURCES bits); 1 = edge, 0 = level.

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  reset; asynchronous, active-high
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_we_i   in  1  write enable
wb_adr_i  in  16  word address; only [2:0] are decoded
wb_dat_i  in  16  write data
wb_dat_o  out  16  read data, registered, valid while wb_ack_o is high
wb_ack_o  out  1  single-cycle acknowledge
irq_i     in  NUM_SOURCES  raw interrupt sources, asynchronous to wb_clk_i
irq_o     out  1  registered interrupt request to the processor

Behaviour:
- Reset (asynchronous, wb_rst_i high):
  - flags = 0, MASK = 0, MODE = MODE_RST, POL = 0.
  - Synchronisers and edge-history registers = 0.
  - wb_ack_o = 0, wb_dat_o = 0, irq_o = 0.
- Input path per source:
  - Two-flop synchroniser, then XOR with POL[i] (POL 1 = active-low). This gives the normalised level L[i].
  - Edge-history register H[i] <= L[i] every clock.
  - Event: edge mode -> L & ~H (rising normalised edge); level mode -> L.
- Latency: irq_i goes active at edge N-1 (setup met). L is high after edge N+1. The flag sets at edge N+2. irq_o rises at edge N+3, provided the source is masked-in.
- Flag update per clock: flag_next = (flag & ~clr) | set. Set wins over a simultaneous clear.
  - A level-mode flag cannot be cleared while its source is still active; it re-sets on the same edge.
  - Flags set regardless of MASK. MASK gates only irq_o and VECTOR.
- irq_o <= |(flag & MASK_ext), where MASK_ext includes the user bit at index NUM_SOURCES.
- Wishbone handshake:
  - Access qualifies when wb_cyc_i & wb_stb_i & ~wb_ack_o.
  - wb_ack_o rises on the next edge and lasts exactly 1 cycle. Back-to-back accesses therefore ack every other cycle.
  - wb_dat_o is loaded on the same edge with register contents as they were before that edge, zero-extended to 16 bits.
  - A write takes effect on the ack edge.
- Register map (wb_adr_i[2:0]):
  - 0 FLAG: read returns flags [NUM_SOURCES:0]. Write is write-1-to-clear over bits [NUM_SOURCES:0].
  - 1 MASK: R/W, bits [NUM_SOURCES:0]; 1 = enabled.
  - 2 MODE: R/W, bits [NUM_SOURCES-1:0].
  - 3 POL: R/W, bits [NUM_SOURCES-1:0].
  - 4 SWIRQ: write 16'hFFFF sets the user flag; any other written value clears it. Read returns the user flag in bit 0.
  - 5 VECTOR: read-only. Bit 15 = any(flag & MASK). Bits [3:0] = lowest index i with flag[i] & MASK[i] (index 0 has highest priority); bits [3:0] = 0 when bit 15 = 0. Bits [14:4] = 0. Reads have no side effects.
  - 6 STATUS: read-only, returns L[NUM_SOURCES-1:0].
  - 7: reads 0, writes ignored, still acked.
- Writes to MODE or POL: on the same edge, H[i] for every changed bit is loaded with the post-change normalised level. This suppresses spurious edge events. Existing flags are not modified.
- Unused upper data bits are ignored on write and read as 0.
- Reset asserted mid-transaction: wb_ack_o drops immediately and the write is discarded.

Test Plan:
- Reset: MASK=0, POL=0, NUM_SOURCES=8 -> FLAG, MASK read 0; MODE reads 16'h00FF; VECTOR reads 16'h0000; irq_o=0 with irq_i toggling.
- Edge source: MASK=16'h01FF, irq_i[3] pulses 1 cycle high -> FLAG=16'h0008; irq_o high 4 edges after pulse; VECTOR=16'h8003. Write FLAG=16'h0008 -> irq_o low 1 cycle after ack.
- Priority: flags 3 and 5 set, MASK enables both -> VECTOR=16'h8003. Clear bit 3 -> VECTOR=16'h8005. MASK bit 5 off -> VECTOR=16'h0000 and irq_o=0, while FLAG still reads 16'h0020.
- Level mode with polarity: MODE[2]=0, POL[2]=1, irq_i[2] held low -> W1C of bit 2 leaves FLAG bit 2 = 1. Drive irq_i[2] high, then W1C -> bit 2 = 0.
- Set/clear collision: W1C of bit 1 on the same edge as a new edge event on source 1 -> FLAG bit 1 = 1.
- User IRQ and POL-write glitch: write SWIRQ=16'hFFFF -> FLAG bit 8 = 1, irq_o=1; write SWIRQ=16'h0001 -> bit 8 = 0. With irq_i[0]=0, write POL=16'h0001 -> no flag set on source 0.

Source files
------------

// File: rtl/irq_vector_controller_if.sv
// Wishbone slave bus bundle for irq_vector_controller.
// Signal names keep the slave-side direction suffixes of the bus they carry.
interface irq_vector_controller_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [15:0] wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;

    modport slave (
        input  wb_cyc_i,
        input  wb_stb_i,
        input  wb_we_i,
        input  wb_adr_i,
        input  wb_dat_i,
        output wb_dat_o,
        output wb_ack_o
    );

    modport master (
        output wb_cyc_i,
        output wb_stb_i,
        output wb_we_i,
        output wb_adr_i,
        output wb_dat_i,
        input  wb_dat_o,
        input  wb_ack_o
    );
endinterface

// File: rtl/irq_vector_controller.sv
// Interrupt aggregator: NUM_SOURCES synchronised hardware sources plus one
// software (user) interrupt at flag index NUM_SOURCES. Each hardware source
// has edge/level mode, polarity, a sticky flag and a mask. A registered irq_o
// and a priority-encoded VECTOR register are presented to the processor.
module irq_vector_controller #(
    parameter int unsigned                NUM_SOURCES = 8,
    parameter logic [NUM_SOURCES-1:0]     MODE_RST    = '1
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    irq_vector_controller_if.slave        wb,
    input  logic [NUM_SOURCES-1:0]        irq_i,
    output logic                          irq_o
);

    localparam int unsigned NS = NUM_SOURCES;

    localparam logic [2:0] ADR_FLAG   = 3'd0;
    localparam logic [2:0] ADR_MASK   = 3'd1;
    localparam logic [2:0] ADR_MODE   = 3'd2;
    localparam logic [2:0] ADR_POL    = 3'd3;
    localparam logic [2:0] ADR_SWIRQ  = 3'd4;
    localparam logic [2:0] ADR_VECTOR = 3'd5;
    localparam logic [2:0] ADR_STATUS = 3'd6;

    // Input path state
    logic [NS-1:0] r_sync1;
    logic [NS-1:0] r_sync2;
    logic [NS-1:0] r_hist;

    // Configuration and status
    logic [NS-1:0] r_mode;
    logic [NS-1:0] r_pol;
    logic [NS:0]   r_mask;
    logic [NS:0]   r_flag;

    // Bus and output registers
    logic          r_ack;
    logic [15:0]   r_dat;
    logic          r_irq;

    // Combinational nets
    logic [2:0]    w_adr;
    logic          w_access;
    logic          w_wr;
    logic          w_wr_flag;
    logic          w_wr_mask;
    logic          w_wr_mode;
    logic          w_wr_pol;
    logic          w_wr_swirq;
    logic [NS-1:0] w_level;
    logic [NS-1:0] w_event;
    logic [NS-1:0] w_mode_next;
    logic [NS-1:0] w_pol_next;
    logic [NS-1:0] w_hist_next;
    logic [NS:0]   w_clr;
    logic [NS:0]   w_flag_next;
    logic [NS:0]   w_pending;
    logic [3:0]    w_vec_idx;
    logic [15:0]   w_vector;
    logic [15:0]   w_rdata;
    logic          w_unused_adr;

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_dat_o = r_dat;
    assign irq_o       = r_irq;

    // Only the low three address bits select a register.
    assign w_adr        = wb.wb_adr_i[2:0];
    assign w_unused_adr = ^wb.wb_adr_i[15:3];

    // One access per ack: the cycle that raises ack cannot start another.
    assign w_access   = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
    assign w_wr       = w_access & wb.wb_we_i;
    assign w_wr_flag  = w_wr & (w_adr == ADR_FLAG);
    assign w_wr_mask  = w_wr & (w_adr == ADR_MASK);
    assign w_wr_mode  = w_wr & (w_adr == ADR_MODE);
    assign w_wr_pol   = w_wr & (w_adr == ADR_POL);
    assign w_wr_swirq = w_wr & (w_adr == ADR_SWIRQ);

    assign w_mode_next = w_wr_mode ? wb.wb_dat_i[NS-1:0] : r_mode;
    assign w_pol_next  = w_wr_pol  ? wb.wb_dat_i[NS-1:0] : r_pol;

    // Normalised level: POL = 1 turns an active-low source into active-high.
    assign w_level = r_sync2 ^ r_pol;

    // Edge mode fires on a rising normalised edge, level mode while active.
    assign w_event = w_level & (~r_mode | ~r_hist);

    // History follows the level under the polarity that will apply next
    // cycle, so a POL write never looks like an edge. A MODE write leaves
    // the polarity alone, so plain tracking already covers it.
    assign w_hist_next = r_sync2 ^ w_pol_next;

    assign w_pending = r_flag & r_mask;

    // Next flag state: write-1-to-clear, with a new event overriding the clear.
    always_comb begin
        w_clr = '0;
        if (w_wr_flag) begin
            w_clr = wb.wb_dat_i[NS:0];
        end
        w_flag_next         = r_flag;
        w_flag_next[NS-1:0] = (r_flag[NS-1:0] & ~w_clr[NS-1:0]) | w_event;
        if (w_wr_swirq) begin
            w_flag_next[NS] = (wb.wb_dat_i == 16'hFFFF);
        end else begin
            w_flag_next[NS] = r_flag[NS] & ~w_clr[NS];
        end
    end

    // Priority encoder over pending sources; index 0 wins.
    always_comb begin
        w_vec_idx = 4'd0;
        for (int i = NS; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_vec_idx = 4'(i);
            end
        end
        w_vector = {|w_pending, 11'b0, w_vec_idx};
    end

    // Read data mux, zero-extended to the bus width.
    always_comb begin
        w_rdata = '0;
        case (w_adr)
            ADR_FLAG:   w_rdata[NS:0]   = r_flag;
            ADR_MASK:   w_rdata[NS:0]   = r_mask;
            ADR_MODE:   w_rdata[NS-1:0] = r_mode;
            ADR_POL:    w_rdata[NS-1:0] = r_pol;
            ADR_SWIRQ:  w_rdata[0]      = r_flag[NS];
            ADR_VECTOR: w_rdata         = w_vector;
            ADR_STATUS: w_rdata[NS-1:0] = w_level;
            default:    w_rdata         = '0;
        endcase
    end

    // Two-flop synchroniser and edge history.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist  <= '0;
        end else begin
            r_sync1 <= irq_i;
            r_sync2 <= r_sync1;
            r_hist  <= w_hist_next;
        end
    end

    // Configuration registers written over the bus.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_mask <= '0;
            r_mode <= MODE_RST;
            r_pol  <= '0;
        end else begin
            if (w_wr_mask) begin
                r_mask <= wb.wb_dat_i[NS:0];
            end
            r_mode <= w_mode_next;
            r_pol  <= w_pol_next;
        end
    end

    // Sticky interrupt flags.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_flag <= '0;
        end else begin
            r_flag <= w_flag_next;
        end
    end

    // Single-cycle acknowledge with read data captured from pre-edge state.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_access;
            if (w_access) begin
                r_dat <= w_rdata;
            end
        end
    end

    // Registered interrupt request from masked-in flags.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |w_pending;
        end
    end

endmodule

// File: tb/tb_irq_vector_controller.sv
// Scoreboard bench for irq_vector_controller: stimulus pushes expected read
// data, a monitor pops and compares on every acknowledge.
module tb_irq_vector_controller;

    localparam int unsigned NS = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] irq;
    logic          irq_o;

    irq_vector_controller_if wb_if ();

    irq_vector_controller #(
        .NUM_SOURCES (NS),
        .MODE_RST    (8'hFF)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (wb_if),
        .irq_i    (irq),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state (settled view of the block).
    logic [NS:0]   m_flag;
    logic [NS:0]   m_mask;
    logic [NS-1:0] m_mode;
    logic [NS-1:0] m_pol;
    logic [NS-1:0] m_irq;

    typedef struct {
        bit          chk;
        logic [15:0] exp;
        logic [2:0]  adr;
    } sb_t;
    sb_t sb[$];

    function automatic void m_reset();
        m_flag = '0;
        m_mask = '0;
        m_mode = '1;
        m_pol  = '0;
    endfunction

    // Level-mode sources that are active hold their flag set.
    function automatic void m_settle();
        m_flag[NS-1:0] = m_flag[NS-1:0] | (~m_mode & (m_irq ^ m_pol));
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] adr);
        logic [15:0] r     = '0;
        logic [NS:0] p     = m_flag & m_mask;
        bit          found = 0;
        case (adr)
            3'd0: r[NS:0]   = m_flag;
            3'd1: r[NS:0]   = m_mask;
            3'd2: r[NS-1:0] = m_mode;
            3'd3: r[NS-1:0] = m_pol;
            3'd4: r[0]      = m_flag[NS];
            3'd5: begin
                for (int i = 0; i <= NS; i++) begin
                    if (p[i] && !found) begin
                        found = 1;
                        r     = 16'h8000 + 16'(i);
                    end
                end
            end
            3'd6: r[NS-1:0] = m_irq ^ m_pol;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops one scoreboard entry.
    always @(negedge clk) begin
        if (wb_if.wb_ack_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_ack: got ack with data %h, expected none", wb_if.wb_dat_o);
            end else begin
                sb_t e;
                e = sb.pop_front();
                if (e.chk) begin
                    n_vec++;
                    if (wb_if.wb_dat_o !== e.exp) begin
                        n_err++;
                        $display("FAIL read_adr%0d: got %h, expected %h",
                                 e.adr, wb_if.wb_dat_o, e.exp);
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the ack has been seen.
    task automatic wb_acc(input bit we, input logic [2:0] adr, input logic [15:0] dat,
                          input bit chk, input logic [15:0] exp);
        sb_t e;
        e.chk = chk;
        e.exp = exp;
        e.adr = adr;
        sb.push_back(e);
        wb_if.wb_cyc_i = 1'b1;
        wb_if.wb_stb_i = 1'b1;
        wb_if.wb_we_i  = we;
        wb_if.wb_adr_i = {13'($urandom), adr};
        wb_if.wb_dat_i = dat;
        @(posedge clk);
        #1;
        wb_if.wb_cyc_i = 1'b0;
        wb_if.wb_stb_i = 1'b0;
        wb_if.wb_we_i  = 1'b0;
        wb_if.wb_dat_i = 16'($urandom);
        for (int k = 0; k < 4 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL ack_timeout_adr%0d: got no ack, expected one", adr);
            sb.delete();
        end
    endtask

    task automatic rd(input logic [2:0] adr);
        wb_acc(1'b0, adr, 16'h0, 1'b1, m_read(adr));
    endtask

    task automatic rd_exp(input logic [2:0] adr, input logic [15:0] exp);
        wb_acc(1'b0, adr, 16'h0, 1'b1, exp);
    endtask

    task automatic wr(input logic [2:0] adr, input logic [15:0] dat);
        wb_acc(1'b1, adr, dat, 1'b0, 16'h0);
        case (adr)
            3'd0: begin m_flag = m_flag & ~dat[NS:0]; m_settle(); end
            3'd1: m_mask = dat[NS:0];
            3'd2: begin m_mode = dat[NS-1:0]; m_settle(); end
            3'd3: begin m_pol = dat[NS-1:0]; m_settle(); end
            3'd4: m_flag[NS] = (dat == 16'hFFFF);
            default: ;
        endcase
    endtask

    task automatic settle_wait();
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic set_irq(input logic [NS-1:0] v);
        logic [NS-1:0] rise;
        rise = ~(m_irq ^ m_pol) & (v ^ m_pol);
        m_flag[NS-1:0] = m_flag[NS-1:0] | (m_mode & rise);
        m_irq = v;
        m_settle();
        irq = v;
        settle_wait();
    endtask

    // A one-cycle toggle always produces a rising normalised edge and an
    // active level at some point, so every pulsed source flags.
    task automatic pulse(input logic [NS-1:0] p);
        irq = m_irq ^ p;
        @(posedge clk);
        #1;
        irq = m_irq;
        m_flag[NS-1:0] = m_flag[NS-1:0] | p;
        m_settle();
        settle_wait();
    endtask

    task automatic chk_irq(input string name);
        @(posedge clk);
        #1;
        check(name, 16'(irq_o), 16'(|(m_flag & m_mask)));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected one");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        irq            = '0;
        m_irq          = '0;
        wb_if.wb_cyc_i = 1'b0;
        wb_if.wb_stb_i = 1'b0;
        wb_if.wb_we_i  = 1'b0;
        wb_if.wb_adr_i = '0;
        wb_if.wb_dat_i = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 16'(wb_if.wb_ack_o), 16'h0);
        check("rst_irq", 16'(irq_o), 16'h0);
        rst = 1'b0;

        // Reset values
        rd_exp(3'd0, 16'h0000);
        rd_exp(3'd1, 16'h0000);
        rd_exp(3'd2, 16'h00FF);
        rd_exp(3'd3, 16'h0000);
        rd_exp(3'd5, 16'h0000);
        rd_exp(3'd7, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            set_irq(NS'($urandom));
            check("masked_irq", 16'(irq_o), 16'h0);
        end
        set_irq('0);
        wr(3'd0, 16'h01FF);
        rd_exp(3'd0, 16'h0000);

        // Edge source and irq_o latency
        wr(3'd1, 16'h01FF);
        irq = 8'h08;
        @(posedge clk);
        #1;
        irq = 8'h00;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("irq_lat_early", 16'(irq_o), 16'h0);
        @(posedge clk);
        #1;
        check("irq_lat", 16'(irq_o), 16'h1);
        m_flag[3] = 1'b1;
        rd_exp(3'd0, 16'h0008);
        rd_exp(3'd5, 16'h8003);
        wr(3'd0, 16'h0008);
        check("irq_clear", 16'(irq_o), 16'h0);

        // Priority
        pulse(8'h28);
        rd_exp(3'd5, 16'h8003);
        wr(3'd0, 16'h0008);
        rd_exp(3'd5, 16'h8005);
        wr(3'd1, 16'h01DF);
        rd_exp(3'd5, 16'h0000);
        chk_irq("irq_masked_off");
        rd_exp(3'd0, 16'h0020);

        // Level mode, active-low source 2
        wr(3'd1, 16'h01FF);
        wr(3'd2, 16'h00FB);
        wr(3'd3, 16'h0004);
        settle_wait();
        wr(3'd0, 16'h0004);
        rd_exp(3'd0, 16'h0024);
        set_irq(8'h04);
        wr(3'd0, 16'h0004);
        rd_exp(3'd0, 16'h0020);

        // Set/clear collision on source 1
        wr(3'd2, 16'h00FF);
        wr(3'd3, 16'h0000);
        set_irq('0);
        wr(3'd0, 16'h01FF);
        irq = 8'h02;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        wr(3'd0, 16'h0002);
        m_irq     = 8'h02;
        m_flag[1] = 1'b1;
        rd_exp(3'd0, 16'h0002);

        // User IRQ and POL-write glitch suppression
        set_irq('0);
        wr(3'd0, 16'h01FF);
        wr(3'd4, 16'hFFFF);
        rd_exp(3'd0, 16'h0100);
        chk_irq("irq_user");
        rd_exp(3'd5, 16'h8008);
        wr(3'd4, 16'h0001);
        rd_exp(3'd0, 16'h0000);
        rd_exp(3'd4, 16'h0000);
        wr(3'd3, 16'h0001);
        settle_wait();
        rd_exp(3'd0, 16'h0000);
        rd_exp(3'd6, 16'h0001);

        // Randomised traffic against the model
        for (int it = 0; it < 300; it++) begin
            int op;
            op = $urandom_range(0, 9);
            case (op)
                0: set_irq(NS'($urandom));
                1: pulse(NS'($urandom) & NS'($urandom));
                2: wr(3'd1, 16'($urandom));
                3: wr(3'd2, 16'($urandom | $urandom));
                4: wr(3'd3, 16'($urandom));
                5: wr(3'd0, 16'($urandom));
                6: wr(3'd4, ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom));
                default: rd(3'($urandom));
            endcase
            chk_irq("irq_rand");
        end

        // Reset during a write before its ack edge: no ack, write lost
        set_irq('0);
        wb_if.wb_cyc_i = 1'b1;
        wb_if.wb_stb_i = 1'b1;
        wb_if.wb_we_i  = 1'b1;
        wb_if.wb_adr_i = 16'h0001;
        wb_if.wb_dat_i = 16'h01FF;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        wb_if.wb_cyc_i = 1'b0;
        wb_if.wb_stb_i = 1'b0;
        wb_if.wb_we_i  = 1'b0;
        check("rst_mid_ack", 16'(wb_if.wb_ack_o), 16'h0);
        rst = 1'b0;
        m_reset();
        rd_exp(3'd1, 16'h0000);

        // Reset right after an ack edge drops ack at once
        wb_if.wb_cyc_i = 1'b1;
        wb_if.wb_stb_i = 1'b1;
        wb_if.wb_we_i  = 1'b0;
        wb_if.wb_adr_i = 16'h0002;
        @(posedge clk);
        #1;
        wb_if.wb_cyc_i = 1'b0;
        wb_if.wb_stb_i = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_ack_drop", 16'(wb_if.wb_ack_o), 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_exp(3'd2, 16'h00FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
